// File: rtl/ora_misr_if.sv
// ora_misr_if: start/done handshake, pattern stream and result bus of the output result analyzer.
// Defining ORA_FIRST_FAIL_EN adds the first_fail / first_fail_vld signals.
interface ora_misr_if #(
    parameter int BIT       = 4,
    parameter int CH        = 2,
    parameter int PAT_CNT_W = 8
);
    logic                 start;
    logic [PAT_CNT_W-1:0] n_pat;
    logic                 valid;
    logic [CH*BIT-1:0]    cut_op;
    logic [CH*BIT-1:0]    ff_op;
    logic                 busy;
    logic                 done;
    logic                 res;
    logic [CH-1:0]        fail_map;
    logic [CH*BIT-1:0]    sig;
`ifdef ORA_FIRST_FAIL_EN
    logic [PAT_CNT_W-1:0] first_fail;
    logic                 first_fail_vld;
    modport master (output start, n_pat, valid, cut_op, ff_op,
                    input busy, done, res, fail_map, sig, first_fail, first_fail_vld);
    modport slave (input start, n_pat, valid, cut_op, ff_op,
                   output busy, done, res, fail_map, sig, first_fail, first_fail_vld);
`else
    modport master (output start, n_pat, valid, cut_op, ff_op,
                    input busy, done, res, fail_map, sig);
    modport slave (input start, n_pat, valid, cut_op, ff_op,
                   output busy, done, res, fail_map, sig);
`endif
endinterface

// File: rtl/ora_misr.sv
// ora_misr: multi-channel LBIST output result analyzer; compacts CUT and reference outputs into MISRs and compares signatures.
// Optional ORA_FIRST_FAIL_EN records the index of the first raw mismatching pattern.
module ora_misr #(
    parameter int             BIT       = 4,
    parameter int             CH        = 2,
    parameter int             PAT_CNT_W = 8,
    parameter logic [BIT-1:0] POLY      = 4'h3
) (
    input logic        clk,
    input logic        rst,
    ora_misr_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CMP, S_DONE} state_t;
    state_t               state, state_nx;
    logic [PAT_CNT_W-1:0] cnt, npat;
    logic [CH*BIT-1:0]    cut_m, ff_m, cut_nx, ff_nx;
    logic [CH-1:0]        mism, fail_map;
    logic                 res, start_ok, shift;

    function automatic logic [BIT-1:0] step(input logic [BIT-1:0] m, input logic [BIT-1:0] d);
        return {m[BIT-2:0], 1'b0} ^ (m[BIT-1] ? POLY : '0) ^ d;
    endfunction

    always_comb begin
        cut_nx = cut_m;
        ff_nx  = ff_m;
        mism   = '0;
        for (int c = 0; c < CH; c++) begin
            cut_nx[c*BIT +: BIT] = step(cut_m[c*BIT +: BIT], bus.cut_op[c*BIT +: BIT]);
            ff_nx[c*BIT +: BIT]  = step(ff_m[c*BIT +: BIT], bus.ff_op[c*BIT +: BIT]);
            mism[c]              = cut_m[c*BIT +: BIT] != ff_m[c*BIT +: BIT];
        end
        start_ok = bus.start && (state == S_IDLE || state == S_DONE);
        shift    = state == S_RUN && bus.valid;
        // An empty run skips RUN; signatures are trivially equal.
        state_nx = start_ok                                     ? (bus.n_pat == '0 ? S_CMP : S_RUN) :
                   shift && cnt + PAT_CNT_W'(1) == npat         ? S_CMP :
                   state == S_CMP                               ? S_DONE : state;
    end

`ifdef ORA_FIRST_FAIL_EN
    logic [PAT_CNT_W-1:0] first_fail;
    logic                 first_fail_vld;
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (shift && !first_fail_vld && bus.cut_op != bus.ff_op) begin
            first_fail     <= cnt;
            first_fail_vld <= 1'b1;
        end
    end
    assign bus.first_fail     = first_fail;
    assign bus.first_fail_vld = first_fail_vld;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            npat     <= '0;
            cut_m    <= '0;
            ff_m     <= '0;
            res      <= 1'b0;
            fail_map <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                cnt      <= '0;
                npat     <= bus.n_pat;
                cut_m    <= '0;
                ff_m     <= '0;
                res      <= 1'b0;
                fail_map <= '0;
            end else if (shift) begin
                cnt   <= cnt + PAT_CNT_W'(1);
                cut_m <= cut_nx;
                ff_m  <= ff_nx;
            end else if (state == S_CMP) begin
                fail_map <= mism;
                res      <= ~|mism;
            end
        end
    end

    assign bus.busy     = state == S_RUN || state == S_CMP;
    assign bus.done     = state == S_DONE;
    assign bus.res      = res;
    assign bus.fail_map = fail_map;
    assign bus.sig      = cut_m;
endmodule

// File: tb/tb_ora_misr.sv
// tb_ora_misr: directed and randomized checks of ora_misr against a polynomial-division signature model.
// Build with ORA_FIRST_FAIL_EN to also check the first-fail index.
module tb_ora_misr;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    logic [7:0] cq[$];
    logic [7:0] fq[$];

    ora_misr_if #(.BIT(4), .CH(2), .PAT_CNT_W(8)) bus ();
    ora_misr #(.BIT(4), .CH(2), .PAT_CNT_W(8), .POLY(4'h3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Signature = D(x) mod (x^4+x+1), with the oldest pattern carrying the highest power of x.
    function automatic logic [3:0] msig(input int ch, input logic [7:0] q[$]);
        logic [63:0] v = '0;
        for (int i = 0; i < q.size(); i++) v ^= 64'(q[i][ch*4 +: 4]) << (q.size() - 1 - i);
        for (int k = 63; k >= 4; k--) if (v[k]) v ^= 64'h13 << (k - 4);
        return v[3:0];
    endfunction

    task automatic run(input string tag, input bit gaps);
        int n = cq.size();
        int sent = 0;
        logic [1:0] fm;
        int ffi = 0;
        bit ffv = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.n_pat = 8'(n);
        bus.valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".busy"}, bus.busy, 1);
        chk({tag, ".res_clr"}, {bus.done, bus.res, bus.fail_map}, 0);
        while (sent < n) begin
            bus.start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.n_pat = 8'($urandom_range(0, 3));
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.valid  = 1'b0;
                bus.cut_op = 8'($urandom);
                bus.ff_op  = 8'($urandom);
            end else begin
                bus.valid  = 1'b1;
                bus.cut_op = cq[sent];
                bus.ff_op  = fq[sent];
                sent++;
            end
            @(negedge clk);
        end
        bus.start  = 1'b0;
        bus.valid  = 1'b0;
        bus.cut_op = 8'($urandom);
        chk({tag, ".cmp_not_done"}, bus.done, 0);
        @(negedge clk);
        chk({tag, ".done"}, {bus.done, bus.busy}, 2'b10);
        fm = {msig(1, cq) != msig(1, fq), msig(0, cq) != msig(0, fq)};
        chk({tag, ".sig"}, bus.sig, {msig(1, cq), msig(0, cq)});
        chk({tag, ".fail_map"}, bus.fail_map, fm);
        chk({tag, ".res"}, bus.res, fm == 2'b00);
`ifdef ORA_FIRST_FAIL_EN
        for (int i = n - 1; i >= 0; i--) if (cq[i] != fq[i]) begin ffi = i; ffv = 1; end
        chk({tag, ".ff"}, {bus.first_fail_vld, bus.first_fail}, {ffv, 8'(ffi)});
`else
        ffi = ffv ? ffi : 0;
`endif
    endtask

    task automatic set_same(input logic [7:0] a[$]);
        cq = a;
        fq = a;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.n_pat = '0;
        bus.valid = 1'b0;
        bus.cut_op = '0;
        bus.ff_op = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset", {bus.busy, bus.done, bus.res, bus.fail_map, bus.sig}, 0);
`ifdef ORA_FIRST_FAIL_EN
        chk("reset.ff", {bus.first_fail_vld, bus.first_fail}, 0);
`endif
        rst = 1'b0;
        set_same('{8'h5A, 8'h3C, 8'h81});
        run("t1", 0);
        set_same('{8'hA5});
        run("t2a", 0);
        chk("t2a.lit", bus.sig, 8'hA5);
        set_same('{8'h11, 8'h22});
        run("t2b", 0);
        chk("t2b.lit", bus.sig, 8'h00);
        set_same('{8'h08, 8'h00});
        run("t2c", 0);
        chk("t2c.lit", bus.sig, 8'h03);
        cq = '{8'hCC, 8'hFC};
        fq = '{8'hCC, 8'hCC};
        run("t3", 0);
        chk("t3.lit", {bus.res, bus.fail_map}, 3'b010);
        set_same('{8'h3E, 8'hC1, 8'h7B, 8'h94});
        run("t4", 1);
        // Reset mid-run after two of five patterns.
        @(negedge clk);
        bus.start = 1'b1;
        bus.n_pat = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.valid = 1'b1;
            bus.cut_op = 8'($urandom);
            bus.ff_op = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        bus.valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t5.rst", {bus.busy, bus.done, bus.res, bus.fail_map, bus.sig}, 0);
        cq.delete();
        fq.delete();
        run("t5.empty", 0);
        chk("t5.lit", {bus.res, bus.sig}, 9'h100);
        set_same('{8'h6D});
        run("t6", 0);
        // Reset wins over a coincident start.
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        bus.n_pat = 8'd3;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        chk("rst_start", {bus.busy, bus.done, bus.res}, 0);
        for (int r = 0; r < 12; r++) begin
            int n = $urandom_range(1, 20);
            cq.delete();
            fq.delete();
            for (int i = 0; i < n; i++) begin
                logic [7:0] d = 8'($urandom);
                cq.push_back(d);
                fq.push_back($urandom_range(0, 4) == 0 ? 8'($urandom) : d);
            end
            run($sformatf("rnd%0d", r), r[0]);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
